spi_burst_ctrl: RTL
===================

Name: spi_burst_ctrl

Overview:
- Byte-stream sequencer between the GPMC-mapped register bank and the byte-level SPI engine (`spi`).
- Buffers host bytes in a TX FIFO and issues them back-to-back to the engine under a single chip-select assertion.
- Collects received bytes into an RX FIFO for host readout.
- Removes per-byte host polling of busy/new_data.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2.
- CS_DELAY, 4, clk cycles of cs_n setup before the first start and hold after the last byte; ≥1.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tx_wr  in  1  push tx_data into TX FIFO
- tx_data  in  8  byte to transmit
- tx_full  out  1  TX FIFO full
- tx_level  out  LVL_W  TX FIFO occupancy
- rx_rd  in  1  pop RX FIFO; rx_data then advances next cycle
- rx_data  out  8  head of RX FIFO (registered, valid when !rx_empty)
- rx_empty  out  1  RX FIFO empty
- rx_level  out  LVL_W  RX FIFO occupancy
- go  in  1  one-cycle pulse: start burst of all TX bytes
- abort  in  1  terminate burst
- clr_ovf  in  1  clear sticky flags
- active  out  1  burst in progress (state != IDLE)
- rx_ovf  out  1  sticky: received byte dropped, RX full
- tx_ovf  out  1  sticky: tx_wr while full, byte dropped
- cs_n  out  1  SPI chip select, active low
- spi_start  out  1  one-cycle start pulse to engine
- spi_data_in  out  8  byte to engine, held stable from spi_start until spi_new_data
- spi_data_out  in  8  byte from engine, valid when spi_new_data
- spi_busy  in  1  engine busy
- spi_new_data  in  1  one-cycle pulse: byte complete

Behaviour:
- Reset (async, rst=1) values:
  - Both FIFOs empty, levels 0, tx_full=0, rx_empty=1, rx_data=0.
  - cs_n=1, spi_start=0, spi_data_in=0, active=0, rx_ovf=0, tx_ovf=0.
  - FSM in IDLE.
- FIFOs:
  - Circular, pointers wrap modulo FIFO_DEPTH, with a separate occupancy counter.
  - Simultaneous push and pop on either FIFO: level unchanged.
  - Push when full is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and the overflow flag is set.
  - Pop when empty is ignored.
- FSM states:
  - IDLE: cs_n=1.
    - go with TX non-empty → SETUP; counter loaded with CS_DELAY-1.
    - go with TX empty: ignored.
  - SETUP: cs_n=0; count down; at 0 → ISSUE.
  - ISSUE: wait for spi_busy=0.
    - Then pop TX head into spi_data_in and pulse spi_start for exactly 1 cycle → WAIT.
  - WAIT: hold spi_data_in; on spi_new_data, push spi_data_out into RX FIFO.
    - If TX non-empty → ISSUE (same cycle transition).
    - Else → HOLD, counter loaded with CS_DELAY-1.
  - HOLD: cs_n=0; count down; at 0 → IDLE, cs_n=1 on the next cycle.
- tx_wr during a burst is legal: bytes pushed before the last byte's new_data extend the same burst.
- go while active: ignored.
- abort, any state: next cycle FSM=IDLE, cs_n=1, spi_start=0, TX FIFO flushed, RX FIFO kept. Any later spi_new_data is ignored.
- rx_ovf/tx_ovf: set on drop; clr_ovf clears. Same-cycle set and clear: set wins.
- Latency:
  - go → cs_n low in 1 cycle.
  - cs_n low → first spi_start after CS_DELAY cycles (busy low).
  - new_data → next spi_start after 1 cycle.
  - new_data → byte visible on rx_data/rx_empty after 1 cycle.

Test Plan:
- Reset mid-burst (rst during WAIT) → all outputs at reset values the same cycle, FIFOs empty, cs_n=1.
- Push 0xA5,0x3C, go; engine model loops back 0x5A,0xC3 → exactly two spi_start pulses, data 0xA5 then 0x3C; cs_n low continuously from 4 cycles before first start to 4 cycles after last new_data; rx reads 0x5A,0xC3; rx_level then 0.
- Push 9 bytes with FIFO_DEPTH=8 → tx_level=8, tx_full=1, tx_ovf=1; clr_ovf → tx_ovf=0.
- Burst of 8 with no rx_rd, then second burst of 1 → rx_ovf=1, rx_level stays 8, RX head still byte 0 of the first burst.
- abort during second byte's WAIT of a 4-byte burst → cs_n=1 next cycle, tx_level=0, rx_level=1, late new_data not captured.
- go with TX empty → no cs_n activity, active stays 0; simultaneous tx_wr+rx_rd at wrap boundary (8 writes/reads) → data order preserved.

Source files
------------

// File: rtl/spi_burst_ctrl_if.sv
// rtl/spi_burst_ctrl_if.sv - host and SPI-engine signal bundle for the burst sequencer
interface spi_burst_ctrl_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
    // host side
    logic             tx_wr;
    logic [7:0]       tx_data;
    logic             tx_full;
    logic [LVL_W-1:0] tx_level;
    logic             rx_rd;
    logic [7:0]       rx_data;
    logic             rx_empty;
    logic [LVL_W-1:0] rx_level;
    logic             go;
    logic             abort;
    logic             clr_ovf;
    logic             active;
    logic             rx_ovf;
    logic             tx_ovf;
    // byte engine side
    logic             cs_n;
    logic             spi_start;
    logic [7:0]       spi_data_in;
    logic [7:0]       spi_data_out;
    logic             spi_busy;
    logic             spi_new_data;

    modport master (
        output tx_wr, tx_data, rx_rd, go, abort, clr_ovf,
        output spi_data_out, spi_busy, spi_new_data,
        input  tx_full, tx_level, rx_data, rx_empty, rx_level,
        input  active, rx_ovf, tx_ovf, cs_n, spi_start, spi_data_in
    );

    modport slave (
        input  tx_wr, tx_data, rx_rd, go, abort, clr_ovf,
        input  spi_data_out, spi_busy, spi_new_data,
        output tx_full, tx_level, rx_data, rx_empty, rx_level,
        output active, rx_ovf, tx_ovf, cs_n, spi_start, spi_data_in
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - TX/RX byte FIFOs and burst sequencer in front of the SPI byte engine
module spi_burst_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CS_DELAY   = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    spi_burst_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (CS_DELAY > 1) ? $clog2(CS_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CS_DELAY - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             spi_start_w;
    logic             rx_push_req_w;

    // TX FIFO
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wptr_q, tx_rptr_q;
    logic [LVL_W-1:0] tx_cnt_q;
    logic             tx_full_w, tx_nonempty_w, tx_push_w, tx_pop_w, tx_drop_w;
    logic [7:0]       tx_head_w;

    // RX FIFO
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wptr_q, rx_rptr_q;
    logic [LVL_W-1:0] rx_cnt_q;
    logic             rx_full_w, rx_nonempty_w, rx_push_w, rx_pop_w, rx_drop_w;

    logic             tx_ovf_q, rx_ovf_q;

    // A byte is only popped by the start pulse, which is only issued with TX non-empty.
    // Abort wins over a same-cycle write: the flushed FIFO does not take the byte.
    assign tx_full_w     = (tx_cnt_q == LVL_FULL);
    assign tx_nonempty_w = (tx_cnt_q != '0);
    assign tx_pop_w      = spi_start_w;
    assign tx_push_w     = bus.tx_wr && !bus.abort && (!tx_full_w || tx_pop_w);
    assign tx_drop_w     = bus.tx_wr && !bus.abort && tx_full_w && !tx_pop_w;
    assign tx_head_w     = tx_mem_q[tx_rptr_q];

    assign rx_full_w     = (rx_cnt_q == LVL_FULL);
    assign rx_nonempty_w = (rx_cnt_q != '0);
    assign rx_pop_w      = bus.rx_rd && rx_nonempty_w;
    assign rx_push_w     = rx_push_req_w && (!rx_full_w || rx_pop_w);
    assign rx_drop_w     = rx_push_req_w && rx_full_w && !rx_pop_w;

    // TX storage write; contents need no reset since only occupied slots are read
    always_ff @(posedge clk) begin
        if (tx_push_w) begin
            tx_mem_q[tx_wptr_q] <= bus.tx_data;
        end
    end

    // TX pointers and occupancy; abort empties the FIFO by catching the read pointer up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else if (bus.abort) begin
            tx_rptr_q <= tx_wptr_q;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push_w) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
            if (tx_pop_w)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
            if (tx_push_w && !tx_pop_w)      tx_cnt_q <= tx_cnt_q + LVL_W'(1);
            else if (!tx_push_w && tx_pop_w) tx_cnt_q <= tx_cnt_q - LVL_W'(1);
        end
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push_w) begin
            rx_mem_q[rx_wptr_q] <= bus.spi_data_out;
        end
    end

    // RX pointers and occupancy; abort leaves received bytes in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push_w) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
            if (rx_pop_w)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
            if (rx_push_w && !rx_pop_w)      rx_cnt_q <= rx_cnt_q + LVL_W'(1);
            else if (!rx_push_w && rx_pop_w) rx_cnt_q <= rx_cnt_q - LVL_W'(1);
        end
    end

    // Sticky drop flags; a drop in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (tx_drop_w)        tx_ovf_q <= 1'b1;
            else if (bus.clr_ovf) tx_ovf_q <= 1'b0;
            if (rx_drop_w)        rx_ovf_q <= 1'b1;
            else if (bus.clr_ovf) rx_ovf_q <= 1'b0;
        end
    end

    // Sequencer state, cs timing counter and the byte presented to the engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next state: the head byte is latched on entry to ISSUE so it is already
    // stable when the start pulse fires, and stays put through WAIT
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        spi_start_w   = 1'b0;
        rx_push_req_w = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.go && tx_nonempty_w) begin
                        state_d = S_SETUP;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        state_d = S_ISSUE;
                        data_d  = tx_head_w;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (!bus.spi_busy) begin
                        spi_start_w = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.spi_new_data) begin
                        rx_push_req_w = 1'b1;
                        if (tx_nonempty_w) begin
                            state_d = S_ISSUE;
                            data_d  = tx_head_w;
                        end else begin
                            state_d = S_HOLD;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.tx_full     = tx_full_w;
    assign bus.tx_level    = tx_cnt_q;
    assign bus.rx_data     = rx_nonempty_w ? rx_mem_q[rx_rptr_q] : 8'h00;
    assign bus.rx_empty    = !rx_nonempty_w;
    assign bus.rx_level    = rx_cnt_q;
    assign bus.active      = (state_q != S_IDLE);
    assign bus.cs_n        = (state_q == S_IDLE);
    assign bus.spi_start   = spi_start_w;
    assign bus.spi_data_in = data_q;
    assign bus.tx_ovf      = tx_ovf_q;
    assign bus.rx_ovf      = rx_ovf_q;
endmodule
